// File: rtl/gcd_pkg.sv
// Shared types and constants for the iterative GCD engine.
package gcd_pkg;

    // Engine control states: wait for a job, iterate, apply the binary
    // common power of two, then present the result.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Algorithm select, sampled with each job.
    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_BIN = 1'b1;

endpackage

// File: rtl/gcd_step.sv
// One iteration of the GCD reduction, purely combinational.
// Covers both the subtractive and the binary (Stein) algorithm. Every
// subtraction takes the smaller operand from the larger one, so nothing wraps.
module gcd_step import gcd_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] aNext_o,
    output logic [WIDTH-1:0] bNext_o,
    output logic             kInc_o,
    output logic             term_o,
    output logic [WIDTH-1:0] r_o
);

    logic             term;
    logic             aGreater;
    logic [WIDTH-1:0] diff;

    // A zero operand or equal operands end the job; the surviving value is
    // the (odd part of the) result, with gcd(0,0) falling out as 0.
    assign term     = (a_i == '0) || (b_i == '0) || (a_i == b_i);
    assign aGreater = (a_i > b_i);
    assign diff     = aGreater ? (a_i - b_i) : (b_i - a_i);
    assign term_o   = term;
    assign r_o      = (a_i == '0) ? b_i : a_i;

    // Next operand pair; on termination the operands are simply held.
    always_comb begin
        aNext_o = a_i;
        bNext_o = b_i;
        kInc_o  = 1'b0;
        if (!term) begin
            if (mode_i == MODE_SUB) begin
                if (aGreater) begin
                    aNext_o = diff;
                end else begin
                    bNext_o = diff;
                end
            end else begin
                unique case ({a_i[0], b_i[0]})
                    2'b00: begin
                        aNext_o = a_i >> 1;
                        bNext_o = b_i >> 1;
                        kInc_o  = 1'b1;
                    end
                    2'b01: aNext_o = a_i >> 1;
                    2'b10: bNext_o = b_i >> 1;
                    default: begin
                        if (aGreater) begin
                            aNext_o = diff >> 1;
                        end else begin
                            bNext_o = diff >> 1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD engine with valid/ready on both sides, one job in flight.
// Holds the operand, power-of-two and iteration registers; the arithmetic of
// each iteration lives in gcd_step.
module gcd_engine import gcd_pkg::*; #(
    parameter int WIDTH  = 8,
    parameter int ITER_W = WIDTH + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_gcd,
    output logic [ITER_W-1:0] out_iters
);

    // k never exceeds WIDTH-1, which always fits in clog2(WIDTH) bits.
    localparam int                KW       = $clog2(WIDTH);
    localparam logic [KW-1:0]     K_ONE    = KW'(1);
    localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);
    localparam logic [ITER_W-1:0] ITER_MAX = '1;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               mode_q;
    logic [KW-1:0]      k_q;
    logic [ITER_W-1:0]  iters_q;
    logic [WIDTH-1:0]   outGcd_q;
    logic [ITER_W-1:0]  outIters_q;
    logic               inReady_q;
    logic               outValid_q;

    logic [WIDTH-1:0]   aStep_d;
    logic [WIDTH-1:0]   bStep_d;
    logic               kInc;
    logic               stepTerm;
    logic [WIDTH-1:0]   stepR;
    logic [ITER_W-1:0]  iters_d;

    gcd_step #(
        .WIDTH (WIDTH)
    ) stepUnit (
        .a_i     (a_q),
        .b_i     (b_q),
        .mode_i  (mode_q),
        .aNext_o (aStep_d),
        .bNext_o (bStep_d),
        .kInc_o  (kInc),
        .term_o  (stepTerm),
        .r_o     (stepR)
    );

    // Iteration count saturates instead of wrapping.
    assign iters_d = (iters_q == ITER_MAX) ? iters_q : (iters_q + ITER_ONE);

    // Control FSM with operand, counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= MODE_SUB;
            k_q        <= '0;
            iters_q    <= '0;
            outGcd_q   <= '0;
            outIters_q <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q       <= in_a;
                        b_q       <= in_b;
                        mode_q    <= in_mode;
                        k_q       <= '0;
                        iters_q   <= '0;
                        inReady_q <= 1'b0;
                        state_q   <= S_CALC;
                    end
                end
                S_CALC: begin
                    iters_q <= iters_d;
                    if (stepTerm) begin
                        if (mode_q == MODE_SUB) begin
                            outGcd_q   <= stepR;
                            outIters_q <= iters_d;
                            outValid_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            a_q     <= stepR;
                            state_q <= S_SHIFT;
                        end
                    end else begin
                        a_q <= aStep_d;
                        b_q <= bStep_d;
                        if (kInc) begin
                            k_q <= k_q + K_ONE;
                        end
                    end
                end
                S_SHIFT: begin
                    outGcd_q   <= a_q << k_q;
                    outIters_q <= iters_q;
                    outValid_q <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out_gcd   = outGcd_q;
    assign out_iters = outIters_q;

endmodule
